// File: rtl/filter_sample_feeder.sv
// filter_sample_feeder: FIFO-buffered, rate-paced sample_trig/filter_done initiator for the biquad cascade.
// Define FEEDER_HOLD_LAST_EN to re-trigger with the held sample when a tick finds the FIFO empty.
module filter_sample_feeder #(
  parameter int DATA_SIZE      = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int DIV_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_SIZE-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  output logic [DATA_SIZE-1:0]          filt_data,
  output logic                          filt_trig,
  input  logic                          filt_done,
  input  logic [DATA_SIZE-1:0]          filt_result,
  output logic [DATA_SIZE-1:0]          m_data,
  output logic                          m_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          clear_flags,
  output logic                          overrun,
  output logic                          underrun,
  output logic                          timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;
  logic [DIV_WIDTH-1:0] div_q, div_load;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t state_q, state_d;
  logic [DATA_SIZE-1:0] data_q, data_d, mdat_q, mdat_d;
  logic trig_q, trig_d, mv_q, mv_d;
  logic ovr_q, und_q, tmo_flag_q;
  logic full, empty, push, pop, tick, fire, done_ok, ovr_f, und_f, tmo_f;
  assign full       = lvl_q == LW'(FIFO_DEPTH);
  assign empty      = lvl_q == '0;
  assign push       = s_valid && !full;
  assign tick       = div_q == '0;
  assign div_load   = (rate_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(3) : rate_div - DIV_WIDTH'(1);
  // done in the trigger cycle itself belongs to no sample we issued
  assign done_ok    = filt_done && !trig_q;
  assign s_ready    = !full;
  assign filt_data  = data_q;
  assign filt_trig  = trig_q;
  assign m_data     = mdat_q;
  assign m_valid    = mv_q;
  assign fifo_level = lvl_q;
  assign overrun    = ovr_q;
  assign underrun   = und_q;
  assign timeout    = tmo_flag_q;
  always_comb begin
    pop     = (state_q == IDLE) && tick && !empty;
`ifdef FEEDER_HOLD_LAST_EN
    fire    = (state_q == IDLE) && tick;
`else
    fire    = pop;
`endif
    und_f   = (state_q == IDLE) && tick && empty;
    ovr_f   = (state_q == BUSY) && tick;
    tmo_f   = (state_q == BUSY) && !done_ok && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    mv_d    = (state_q == BUSY) && done_ok;
    trig_d  = fire;
    data_d  = pop ? mem_q[rd_q] : data_q;
    mdat_d  = mv_d ? filt_result : mdat_q;
    tmo_d   = (state_q == BUSY) ? tmo_q + TW'(1) : '0;
    state_d = fire ? BUSY : (mv_d || tmo_f) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      div_q      <= div_load;
      tmo_q      <= '0;
      state_q    <= IDLE;
      data_q     <= '0;
      mdat_q     <= '0;
      trig_q     <= 1'b0;
      mv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      lvl_q      <= lvl_q + LW'(push) - LW'(pop);
      div_q      <= tick ? div_load : div_q - DIV_WIDTH'(1);
      tmo_q      <= tmo_d;
      state_q    <= state_d;
      data_q     <= data_d;
      mdat_q     <= mdat_d;
      trig_q     <= trig_d;
      mv_q       <= mv_d;
      ovr_q      <= (ovr_q && !clear_flags) || ovr_f;
      und_q      <= (und_q && !clear_flags) || und_f;
      tmo_flag_q <= (tmo_flag_q && !clear_flags) || tmo_f;
    end
  end
endmodule

// File: tb/tb_filter_sample_feeder.sv
// tb_filter_sample_feeder: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_filter_sample_feeder;
  localparam int DW = 24, D = 8, VW = 16, TMO = 1023;
  logic clk = 0, reset = 1, s_valid = 0, filt_done = 0, clear_flags = 0;
  logic [DW-1:0] s_data = 0, filt_result = 0;
  logic [VW-1:0] rate_div = 10;
  logic s_ready, filt_trig, m_valid, overrun, underrun, timeout;
  logic [DW-1:0] filt_data, m_data;
  logic [3:0] fifo_level;
  filter_sample_feeder dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rate_div(rate_div), .filt_data(filt_data), .filt_trig(filt_trig), .filt_done(filt_done),
    .filt_result(filt_result), .m_data(m_data), .m_valid(m_valid), .fifo_level(fifo_level),
    .clear_flags(clear_flags), .overrun(overrun), .underrun(underrun), .timeout(timeout)
  );
  always #5 clk = ~clk;
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, edge_n);
  endtask
  // reference model: sample FIFO as a queue, pacing as absolute edge numbers
  int edge_n = 0, next_tick = 0, p_edge = 0;
  bit busy = 0, chk_en = 0, tick, push, ovr_n, und_n, tmo_n;
  logic [DW-1:0] q[$];
  logic e_trig, e_mv, e_ovr, e_und, e_tmo;
  logic [DW-1:0] e_data, e_md;
  function automatic int per(input logic [VW-1:0] r);
    return (r < 4) ? 4 : int'(r);
  endfunction
  always @(posedge clk) begin
    edge_n++;
    e_trig = 0; e_mv = 0;
    if (reset) begin
      q.delete(); busy = 0; e_data = 0; e_md = 0; e_ovr = 0; e_und = 0; e_tmo = 0;
      next_tick = edge_n + per(rate_div);
    end else begin
      ovr_n = 0; und_n = 0; tmo_n = 0;
      tick = (edge_n == next_tick);
      if (tick) next_tick = edge_n + per(rate_div);
      push = s_valid && q.size() < D;
      if (busy) begin
        if (filt_done && edge_n > p_edge + 1) begin busy = 0; e_mv = 1; e_md = filt_result; end
        else if (edge_n - p_edge == TMO) begin busy = 0; tmo_n = 1; end
        ovr_n = tick;
      end else if (tick) begin
        if (q.size() > 0) begin e_data = q.pop_front(); e_trig = 1; busy = 1; p_edge = edge_n; end
        else begin
          und_n = 1;
`ifdef FEEDER_HOLD_LAST_EN
          e_trig = 1; busy = 1; p_edge = edge_n;
`endif
        end
      end
      if (push) q.push_back(s_data);
      e_ovr = (e_ovr && !clear_flags) || ovr_n;
      e_und = (e_und && !clear_flags) || und_n;
      e_tmo = (e_tmo && !clear_flags) || tmo_n;
    end
  end
  // per-cycle compare, event log, and cascade responder
  int trig_e[$], mv_cnt = 0, pend = 0, lat = 4, l;
  logic [DW-1:0] trig_d[$];
  bit rand_lat = 0, spur = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("filt_trig", filt_trig, e_trig);
      chk("filt_data", filt_data, e_data);
      chk("m_valid", m_valid, e_mv);
      chk("m_data", m_data, e_md);
      chk("fifo_level", fifo_level, q.size());
      chk("s_ready", s_ready, q.size() < D);
      chk("overrun", overrun, e_ovr);
      chk("underrun", underrun, e_und);
      chk("timeout", timeout, e_tmo);
    end
    if (filt_trig) begin trig_e.push_back(edge_n); trig_d.push_back(filt_data); end
    if (m_valid) mv_cnt++;
    filt_done = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin filt_done = 1; filt_result = ~filt_data; end
    end
    if (filt_trig) begin
      l = rand_lat ? $urandom_range(2, 14) : lat;
      if (l == 1) begin filt_done = 1; filt_result = ~filt_data; end
      else if (l > 1) pend = l - 1;
    end
    if (spur && !filt_done && $urandom_range(0, 15) == 0) begin filt_done = 1; filt_result = DW'($urandom); end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic do_reset(input logic [VW-1:0] rd);
    reset = 1; rate_div = rd; step(); reset = 0;
    trig_e.delete(); trig_d.delete(); mv_cnt = 0;
  endtask
  task automatic push_one(input logic [DW-1:0] d);
    s_valid = 1; s_data = d; step(); s_valid = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    int p, pp;
    step(); do_reset(10); chk_en = 1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    // three samples, fast cascade
    lat = 4;
    push_one(100); push_one(200); push_one(300);
    repeat (33) step();
    chk("t1_trigs", trig_e.size(), 3);
    if (trig_e.size() == 3) begin
      chk("t1_gap0", trig_e[1] - trig_e[0], 10);
      chk("t1_gap1", trig_e[2] - trig_e[1], 10);
      chk("t1_d0", trig_d[0], 100);
      chk("t1_d1", trig_d[1], 200);
      chk("t1_d2", trig_d[2], 300);
    end
    chk("t1_mv", mv_cnt, 3);
    chk("t1_mdata", m_data, 24'hFFFED3);
    chk("t1_flags", {overrun, underrun, timeout}, 0);
    // fill FIFO with no ticks
    do_reset(1000);
    s_valid = 1;
    for (int i = 0; i < 9; i++) begin s_data = DW'(i + 1); step(); end
    s_valid = 0;
    chk("t2_level", fifo_level, 8);
    chk("t2_ready", s_ready, 0);
    // slow cascade -> dropped tick
    lat = 15; do_reset(10);
    push_one(100); push_one(200);
    repeat (53) step();
    chk("t3_ovr", overrun, 1);
    chk("t3_trigs", trig_e.size(), 2);
    chk("t3_mv", mv_cnt, 2);
    chk("t3_mdata", m_data, 24'hFFFF37);
    // empty FIFO ticks
    clear_flags = 1; rate_div = 6; step(); clear_flags = 0;
    trig_e.delete(); trig_d.delete();
    repeat (20) step();
    chk("t4_und", underrun, 1);
`ifdef FEEDER_HOLD_LAST_EN
    chk("t4_trig", trig_e.size() > 0, 1);
    if (trig_e.size() > 0) chk("t4_hold", trig_d[0], 200);
`else
    chk("t4_trigs", trig_e.size(), 0);
    chk("t4_ovr", overrun, 0);
`endif
    // cascade answers only in the trigger cycle -> timeout
    lat = 1; do_reset(20);
    push_one(24'h123456);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin @(negedge clk); found = filt_trig; end
    chk("t5_trig_seen", found, 1);
    p = edge_n; found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin @(negedge clk); found = timeout; end
    chk("t5_tmo_seen", found, 1);
    chk("t5_tmo_lat", edge_n - p, TMO);
    chk("t5_no_mv", mv_cnt, 0);
    step(); lat = 4;
    push_one(24'h000042);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin @(negedge clk); found = m_valid; end
    chk("t5_mv_after", found, 1);
    chk("t5_mdata", m_data, 24'hFFFFBD);
    step(); rate_div = 5000;
    repeat (25) step();
    clear_flags = 1; step(); clear_flags = 0;
    chk("t5_clr", {overrun, underrun, timeout}, 0);
    // reset while BUSY, done arrives afterwards
    lat = 6; do_reset(8);
    push_one(7);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = filt_trig; end
    chk("t6_trig_seen", found, 1);
    step(); step();
    reset = 1; step(); reset = 0;
    repeat (5) step();
    chk("t6_no_mv", mv_cnt, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_outs", {filt_trig, m_valid, overrun, underrun, timeout}, 0);
    chk("t6_fdata", filt_data, 0);
    chk("t6_mdata", m_data, 0);
    // randomized traffic
    rand_lat = 1; spur = 1; do_reset(7);
    pp = 2;
    for (int i = 0; i < 6000; i++) begin
      if (i % 400 == 0) pp = $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) rate_div = VW'($urandom_range(0, 14));
      s_valid = $urandom_range(0, 7) < pp;
      s_data = DW'($urandom);
      clear_flags = $urandom_range(0, 49) == 0;
      reset = $urandom_range(0, 1499) == 0;
      step();
    end
    s_valid = 0; clear_flags = 0; reset = 0;
    step();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
